// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the core's instruction
// fetch (IF) and load/store (LS) clients and the single 8-bit RAM/IO port.
// LS has priority over IF. Each 1/2/4-byte access is split into sequential
// byte cycles. Reads see their data one cycle after the address is issued.
// Writes to the IO window are held off while the host IO buffer is full.
module mem_ctrl #(
   parameter logic [1:0] IO_HI = 2'b11
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg, cnt_next;        // bytes issued so far
   logic [2:0]  n_reg, n_next;            // transfer length in bytes
   logic [31:0] addr_reg, addr_next;
   logic [31:0] wdata_reg, wdata_next;
   logic        we_reg, we_next;
   logic        is_if_reg, is_if_next;
   logic [31:0] buf_reg, buf_next;        // read assembly buffer
   logic [31:0] if_data_reg, if_data_next;
   logic [31:0] ls_rdata_reg, ls_rdata_next;
   logic [31:0] hold_a_reg;               // bus address of the last active cycle
   logic [7:0]  dout_reg;                 // last byte driven on mem_dout

   logic [31:0] a_comb;
   logic        wr_comb;
   logic [7:0]  dout_comb;
   logic [2:0]  ls_n;
   logic [31:0] cur_a;
   logic [1:0]  cap_idx;
   logic [31:0] merged;
   logic [7:0]  wlane [4];
   logic        io_blocked;

   // Byte count requested by LS; size 11 behaves like a word.
   assign ls_n = (ls_size == 2'b00) ? 3'd1 :
                 (ls_size == 2'b01) ? 3'd2 : 3'd4;

   // Address of the byte the counter points at (wraps at 2^32).
   assign cur_a = addr_reg + {29'd0, cnt_reg};

   // Byte arriving on mem_din belongs to the byte issued one cycle earlier.
   assign cap_idx = cnt_reg[1:0] - 2'd1;

   // IO writes wait while the host buffer cannot take another byte.
   assign io_blocked = (addr_reg[17:16] == IO_HI) && io_buffer_full;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign merged[8*gi +: 8] = (cap_idx == 2'(gi)) ? mem_din : buf_reg[8*gi +: 8];
         assign wlane[gi]         = wdata_reg[8*gi +: 8];
      end
   endgenerate

   // Next-state, byte sequencing and bus outputs; nothing advances while rdy_in is low.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      n_next        = n_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      we_next       = we_reg;
      is_if_next    = is_if_reg;
      buf_next      = buf_reg;
      if_data_next  = if_data_reg;
      ls_rdata_next = ls_rdata_reg;
      a_comb        = 32'd0;
      wr_comb       = 1'b0;
      dout_comb     = dout_reg;
      if_done       = 1'b0;
      ls_done       = 1'b0;
      if (rdy_in) begin
         case (state_reg)
            IDLE: begin
               if (ls_req) begin
                  addr_next  = ls_addr;
                  n_next     = ls_n;
                  we_next    = ls_we;
                  wdata_next = ls_wdata;
                  is_if_next = 1'b0;
                  cnt_next   = 3'd0;
                  buf_next   = 32'd0;
                  state_next = ls_we ? WRITE : READ;
               end else if (if_req && !flush) begin
                  addr_next  = if_addr;
                  n_next     = 3'd4;
                  we_next    = 1'b0;
                  wdata_next = 32'd0;
                  is_if_next = 1'b1;
                  cnt_next   = 3'd0;
                  buf_next   = 32'd0;
                  state_next = READ;
               end
            end
            READ: begin
               if (is_if_reg && flush) begin
                  // Mispredict: drop the fetch, in-flight bytes are discarded.
                  state_next = IDLE;
               end else begin
                  if (cnt_reg != 3'd0) begin
                     buf_next = merged;
                  end
                  if (cnt_reg < n_reg) begin
                     a_comb   = cur_a;
                     cnt_next = cnt_reg + 3'd1;
                  end else begin
                     // Final cycle only captures the last byte.
                     state_next = DONE;
                     if (is_if_reg) begin
                        if_data_next = merged;
                     end else begin
                        ls_rdata_next = merged;
                     end
                  end
               end
            end
            WRITE: begin
               if (!io_blocked) begin
                  a_comb    = cur_a;
                  wr_comb   = 1'b1;
                  dout_comb = wlane[cnt_reg[1:0]];
                  cnt_next  = cnt_reg + 3'd1;
                  if (cnt_reg + 3'd1 == n_reg) begin
                     state_next = DONE;
                  end
               end
            end
            DONE: begin
               if (is_if_reg) begin
                  if_done = !flush;
               end else begin
                  ls_done = 1'b1;
               end
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // While paused the bus keeps presenting the last active address, so the
   // pending read byte is effectively re-issued and arrives on resume.
   assign mem_a    = rdy_in ? a_comb : hold_a_reg;
   assign mem_wr   = wr_comb;
   assign mem_dout = dout_comb;
   assign if_data  = if_data_reg;
   assign ls_rdata = ls_rdata_reg;

   // State and datapath registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_reg    <= IDLE;
         cnt_reg      <= 3'd0;
         n_reg        <= 3'd0;
         addr_reg     <= 32'd0;
         wdata_reg    <= 32'd0;
         we_reg       <= 1'b0;
         is_if_reg    <= 1'b0;
         buf_reg      <= 32'd0;
         if_data_reg  <= 32'd0;
         ls_rdata_reg <= 32'd0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         n_reg        <= n_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         we_reg       <= we_next;
         is_if_reg    <= is_if_next;
         buf_reg      <= buf_next;
         if_data_reg  <= if_data_next;
         ls_rdata_reg <= ls_rdata_next;
      end
   end

   // Remember bus address and write byte for pauses and idle hold.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         hold_a_reg <= 32'd0;
         dout_reg   <= 8'd0;
      end else begin
         if (rdy_in) begin
            hold_a_reg <= a_comb;
         end
         dout_reg <= dout_comb;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios plus randomized single-client transfers
// for mem_ctrl, checked against a byte-addressed reference memory and
// cycle rules (read done at n+2, write done at n+1, +1 per paused cycle).
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, flush, if_req, ls_req, ls_we, io_buffer_full;
   logic [31:0] if_addr, ls_addr, ls_wdata, if_data, ls_rdata, mem_a;
   logic [1:0]  ls_size;
   logic        if_done, ls_done, mem_wr;
   logic [7:0]  mem_din, mem_dout;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk_in = ~clk_in;

   mem_ctrl #(.IO_HI(2'b11)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   // RAM seen by the DUT, and the bench's own view of what memory should hold.
   logic [7:0] ram     [bit [31:0]];
   logic [7:0] ref_mem [bit [31:0]];

   function automatic logic [7:0] init_byte(input bit [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ram_rd(input bit [31:0] a);
      return ram.exists(a) ? ram[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input bit [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   // One-cycle-latency synchronous RAM.
   always @(posedge clk_in) begin
      if (mem_wr) ram[mem_a] = mem_dout;
      mem_din <= ram_rd(mem_a);
   end

   task automatic preload(input bit [31:0] a, input logic [7:0] d);
      ram[a]     = d;
      ref_mem[a] = d;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Per-cycle log of the last transaction.
   logic [31:0] a_log [64];
   logic        wr_log [64];
   logic [7:0]  d_log [64];
   int          if_done_cyc, ls_done_cyc, n_cyc;
   logic [31:0] if_got, ls_got;
   bit          extra_done;

   // Cycle 0 starts at the call (posedge+1); requests held until done.
   task automatic run_txn(input bit use_if, input bit use_ls, input bit we, input logic [1:0] size,
                          input logic [31:0] ia, input logic [31:0] la, input logic [31:0] wd,
                          input logic [63:0] rdy_low, input logic [63:0] full_m, input logic [63:0] flush_m);
      bit if_seen, ls_seen;
      int c;
      if_seen = !use_if;
      ls_seen = !use_ls;
      extra_done  = 1'b0;
      if_done_cyc = -1;
      ls_done_cyc = -1;
      for (int i = 0; i < 64; i++) begin
         a_log[i] = '0; wr_log[i] = 1'b0; d_log[i] = '0;
      end
      if_addr = ia; ls_addr = la; ls_we = we; ls_size = size; ls_wdata = wd;
      c = 0;
      while (!(if_seen && ls_seen) && c < 64) begin
         if_req = !if_seen;
         ls_req = !ls_seen;
         rdy_in = !rdy_low[c];
         io_buffer_full = full_m[c];
         flush = flush_m[c];
         @(negedge clk_in);
         a_log[c] = mem_a; wr_log[c] = mem_wr; d_log[c] = mem_dout;
         if (if_done) begin
            if (if_seen) extra_done = 1'b1;
            else begin if_seen = 1'b1; if_done_cyc = c; if_got = if_data; end
         end
         if (ls_done) begin
            if (ls_seen) extra_done = 1'b1;
            else begin ls_seen = 1'b1; ls_done_cyc = c; ls_got = ls_rdata; end
         end
         @(posedge clk_in); #1;
         c++;
      end
      if_req = 1'b0; ls_req = 1'b0; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
      n_cyc = c;
      if (!(if_seen && ls_seen)) check("timeout", 32'd0, 32'd1);
      check("no_extra_done", 32'(extra_done), 32'd0);
   endtask

   // Done lands on the (base+1)-th cycle with rdy high, counting from cycle 0.
   function automatic int exp_done(input int base, input logic [63:0] rdy_low);
      int hi = 0;
      for (int c = 0; c < 64; c++) begin
         if (!rdy_low[c]) begin
            hi++;
            if (hi == base + 1) return c;
         end
      end
      return -2;
   endfunction

   logic [31:0] pool [6] = '{32'hFFFF_FFFD, 32'h0000_1000, 32'h0000_1003,
                             32'h0003_0010, 32'h0000_0200, 32'h8000_0000};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int fw, zeros_done;
      rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; if_req = 1'b0; ls_req = 1'b0;
      ls_we = 1'b0; ls_size = 2'b00; if_addr = '0; ls_addr = '0; ls_wdata = '0;
      io_buffer_full = 1'b0;
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b0;
      @(negedge clk_in);
      check("rst_mem_a", mem_a, 32'd0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_mem_dout", 32'(mem_dout), 32'd0);
      check("rst_if_done", 32'(if_done), 32'd0);
      check("rst_ls_done", 32'(ls_done), 32'd0);
      check("rst_if_data", if_data, 32'd0);
      check("rst_ls_rdata", ls_rdata, 32'd0);
      @(posedge clk_in); #1;

      // Word fetch at 0x100.
      preload(32'h100, 8'h13); preload(32'h101, 8'h05);
      preload(32'h102, 8'h10); preload(32'h103, 8'h00);
      run_txn(1, 0, 0, 2'b10, 32'h100, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) check("if_addr_seq", a_log[k+1], 32'h100 + 32'(k));
      check("if_done_cyc", 32'(if_done_cyc), 32'd6);
      check("if_data", if_got, 32'h0010_0513);
      $display("[TB] txn fetch 0x100 done@%0d data=0x%08h", if_done_cyc, if_got);

      // Half store at 0x204.
      run_txn(0, 1, 1, 2'b01, 0, 32'h204, 32'hDEAD_BEEF, 0, 0, 0);
      check("hs_wr1", 32'(wr_log[1]), 32'd1);
      check("hs_wr2", 32'(wr_log[2]), 32'd1);
      check("hs_wr3", 32'(wr_log[3]), 32'd0);
      check("hs_a1", a_log[1], 32'h204);
      check("hs_a2", a_log[2], 32'h205);
      check("hs_d1", 32'(d_log[1]), 32'hEF);
      check("hs_d2", 32'(d_log[2]), 32'hBE);
      check("hs_done_cyc", 32'(ls_done_cyc), 32'd3);
      ref_mem[32'h204] = 8'hEF; ref_mem[32'h205] = 8'hBE;
      $display("[TB] txn half store 0x204 done@%0d", ls_done_cyc);

      // Simultaneous requests: LS first, IF right after LS done.
      preload(32'h8, 8'h80);
      run_txn(1, 1, 0, 2'b00, 32'h100, 32'h8, 0, 0, 0, 0);
      check("arb_ls_done_cyc", 32'(ls_done_cyc), 32'd3);
      check("arb_ls_data", ls_got, 32'h0000_0080);
      check("arb_if_issue", a_log[5], 32'h100);
      check("arb_if_done_cyc", 32'(if_done_cyc), 32'd10);
      check("arb_if_data", if_got, 32'h0010_0513);
      $display("[TB] txn arbitration ls@%0d if@%0d", ls_done_cyc, if_done_cyc);

      // IO byte store stalled by a full buffer in cycles 1..5.
      run_txn(0, 1, 1, 2'b00, 0, 32'h3_0000, 32'h0000_005A, 0, 64'h3E, 0);
      fw = -1;
      for (int c = 0; c < n_cyc; c++) if (wr_log[c] && fw < 0) fw = c;
      check("io_first_wr", 32'(fw), 32'd6);
      check("io_dout", 32'(d_log[6]), 32'h5A);
      check("io_done_cyc", 32'(ls_done_cyc), 32'd7);
      ref_mem[32'h3_0000] = 8'h5A;
      $display("[TB] txn io store 0x30000 done@%0d", ls_done_cyc);

      // Flush in cycle 2 aborts the fetch; the held request restarts in cycle 3.
      run_txn(1, 0, 0, 2'b10, 32'h100, 0, 0, 0, 0, 64'h4);
      check("fl_reissue", a_log[4], 32'h100);
      check("fl_done_cyc", 32'(if_done_cyc), 32'd9);
      check("fl_data", if_got, 32'h0010_0513);
      $display("[TB] txn flushed fetch done@%0d", if_done_cyc);

      // Word load paused by rdy_in low in cycles 2..4.
      preload(32'h400, 8'h44); preload(32'h401, 8'h33);
      preload(32'h402, 8'h22); preload(32'h403, 8'h11);
      run_txn(0, 1, 0, 2'b10, 0, 32'h400, 0, 64'h1C, 0, 0);
      check("rdy_done_cyc", 32'(ls_done_cyc), 32'd9);
      check("rdy_data", ls_got, 32'h1122_3344);
      $display("[TB] txn paused load 0x400 done@%0d data=0x%08h", ls_done_cyc, ls_got);

      // Randomized single-client transfers.
      for (int t = 0; t < 40; t++) begin
         bit          is_if, we;
         logic [1:0]  sz;
         int          n, k;
         logic [31:0] a, wd, exp;
         logic [63:0] rl;
         is_if = ($urandom_range(0, 3) == 0);
         we    = !is_if && ($urandom_range(0, 1) == 1);
         sz    = 2'($urandom_range(0, 3));
         n     = is_if ? 4 : (sz == 2'b00 ? 1 : (sz == 2'b01 ? 2 : 4));
         a     = pool[$urandom_range(0, 5)] + 32'($urandom_range(0, 3));
         wd    = $urandom;
         rl    = '0;
         for (int c = 0; c < 16; c++) if ($urandom_range(0, 4) == 0) rl[c] = 1'b1;
         run_txn(is_if, !is_if, we, sz, a, a, wd, rl, 0, 0);
         check("rnd_done_cyc", 32'(is_if ? if_done_cyc : ls_done_cyc),
               32'(exp_done(we ? n + 1 : n + 2, rl)));
         k = 0;
         for (int c = 0; c < n_cyc; c++) begin
            if (wr_log[c]) begin
               check("rnd_wr_addr", a_log[c], a + 32'(k));
               if (k < 4) check("rnd_wr_data", 32'(d_log[c]), 32'(wd[8*k +: 8]));
               k++;
            end
         end
         check("rnd_wr_count", 32'(k), 32'(we ? n : 0));
         if (we) begin
            for (int j = 0; j < n; j++) ref_mem[a + 32'(j)] = wd[8*j +: 8];
         end else begin
            exp = '0;
            for (int j = 0; j < n; j++) exp[8*j +: 8] = ref_rd(a + 32'(j));
            check("rnd_rdata", is_if ? if_got : ls_got, exp);
         end
         $display("[TB] txn %0d %s addr=0x%08h n=%0d done@%0d", t,
                  is_if ? "fetch" : (we ? "store" : "load"), a, n,
                  is_if ? if_done_cyc : ls_done_cyc);
      end

      // Asynchronous reset in the middle of a word load.
      ls_addr = 32'h400; ls_size = 2'b10; ls_we = 1'b0; ls_req = 1'b1; rdy_in = 1'b1;
      repeat (2) begin @(posedge clk_in); #1; end
      check("prerst_mem_a", mem_a, 32'h401);
      #2 rst_in = 1'b1;
      #1;
      check("arst_mem_a", mem_a, 32'd0);
      check("arst_mem_wr", 32'(mem_wr), 32'd0);
      check("arst_mem_dout", 32'(mem_dout), 32'd0);
      check("arst_ls_done", 32'(ls_done), 32'd0);
      check("arst_if_data", if_data, 32'd0);
      check("arst_ls_rdata", ls_rdata, 32'd0);
      ls_req = 1'b0;
      @(posedge clk_in); #1 rst_in = 1'b0;
      zeros_done = 0;
      repeat (8) begin
         @(negedge clk_in);
         if (ls_done || if_done) zeros_done++;
      end
      check("arst_no_done", 32'(zeros_done), 32'd0);
      $display("[TB] txn reset mid-load");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
